// File: rtl/arm_fetch_unit.sv
// arm_fetch_unit: instruction-side reader for port 0 of the unified memory.
// It issues word-aligned reads, queues the returned words in a prefetch FIFO,
// and hands them to decode over a valid/ready handshake.
//
// Handshake: a head entry is offered while instr_valid=1 and is consumed on
// any posedge where instr_valid && instr_ready. While instr_ready=0 the head
// outputs hold. A redirect in the same cycle takes priority and the pop is
// ignored.
//
// Optional build macro FETCH_STATS_EN adds the stat_fetched/stat_flushed
// counters and their ports.
module arm_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_excpt,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_fault,
  output logic        halted
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0] stat_fetched,
  output logic [31:0] stat_flushed
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FAULT = 1'b1
  } state_t;

  state_t        state_q;
  logic          halted_q;
  logic [31:0]   pc_q;
  logic          inflight_q;
  logic          infl_epoch_q;
  logic [31:0]   infl_pc_q;
  logic          epoch_q;
  logic [CW-1:0] count_q;
  logic [PW-1:0] rd_ptr_q;
  logic [PW-1:0] wr_ptr_q;

  logic [31:0]   data_mem  [DEPTH];
  logic [31:0]   pc_mem    [DEPTH];
  logic          fault_mem [DEPTH];

  logic          resp_live;
  logic          push;
  logic          pop;
  logic          issue;
  logic [CW:0]   occupancy;

  // The low address bits of a redirect target are discarded by design.
  logic          unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // A returning read is kept only if no redirect has happened since it issued
  // and the unit has not faulted in the meantime.
  assign resp_live = inflight_q && (infl_epoch_q == epoch_q) && (state_q == ST_RUN);
  assign push      = resp_live && !redirect;
  assign pop       = instr_valid && instr_ready && !redirect;

  // Reserve a FIFO slot for every outstanding read so a response always fits.
  assign occupancy = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
  assign issue     = (state_q == ST_RUN) && fetch_en && !redirect &&
                     (occupancy < (CW+1)'(DEPTH));

  assign mem_addr    = pc_q;
  assign mem_we      = 1'b0;
  assign mem_wdata   = 32'h0;
  assign instr_valid = (count_q != '0);
  assign instr       = instr_valid ? data_mem[rd_ptr_q]  : 32'h0;
  assign instr_pc    = instr_valid ? pc_mem[rd_ptr_q]    : 32'h0;
  assign instr_fault = instr_valid ? fault_mem[rd_ptr_q] : 1'b0;
  assign halted      = halted_q;

  // Control FSM: fetch pointer, in-flight tracking, FIFO bookkeeping, RUN/FAULT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_RUN;
      halted_q     <= 1'b0;
      pc_q         <= {RESET_PC[31:2], 2'b00};
      inflight_q   <= 1'b0;
      infl_epoch_q <= 1'b0;
      infl_pc_q    <= 32'h0;
      epoch_q      <= 1'b0;
      count_q      <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
    end else begin
      inflight_q <= issue;
      if (issue) begin
        infl_pc_q    <= pc_q;
        infl_epoch_q <= epoch_q;
      end
      if (redirect) begin
        pc_q     <= {redirect_pc[31:2], 2'b00};
        epoch_q  <= ~epoch_q;
        state_q  <= ST_RUN;
        halted_q <= 1'b0;
        count_q  <= '0;
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        if (issue) pc_q <= pc_q + 32'd4;
        if (push && mem_excpt) begin
          state_q  <= ST_FAULT;
          halted_q <= 1'b1;
        end
        if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
        count_q <= count_q + CW'(push) - CW'(pop);
      end
    end
  end

  // FIFO storage: write the returning word with its address and fault tag.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr_q]  <= mem_rdata;
      pc_mem[wr_ptr_q]    <= infl_pc_q;
      fault_mem[wr_ptr_q] <= mem_excpt;
    end
  end

`ifdef FETCH_STATS_EN
  logic [31:0] fetched_q;
  logic [31:0] flushed_q;
  logic [CW:0] flush_amt;

  assign flush_amt    = {1'b0, count_q} + {{CW{1'b0}}, resp_live};
  assign stat_fetched = fetched_q;
  assign stat_flushed = flushed_q;

  // Statistics: accepted pops, and entries/live reads thrown away by redirects.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetched_q <= 32'h0;
      flushed_q <= 32'h0;
    end else begin
      if (pop)      fetched_q <= fetched_q + 32'd1;
      if (redirect) flushed_q <= flushed_q + 32'(flush_amt);
    end
  end
`endif

endmodule
